// File: rtl/missile_alien_collide.sv
// Per-frame player-missile vs. alien-formation collision scanner.
// Owns the alive bitmap and emits one kill (with points) per frame at most.
module missile_alien_collide #(
  parameter int ROWS      = 5,
  parameter int COLS      = 11,
  parameter int ALIEN_W   = 24,
  parameter int ALIEN_H   = 16,
  parameter int COL_PITCH = 32,
  parameter int ROW_PITCH = 24,
  parameter int MISSILE_W = 4,
  parameter int MISSILE_H = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 missile_exists,
  input  logic [9:0]           playerMissileX,
  input  logic [9:0]           playerMissileY,
  input  logic [9:0]           alienX,
  input  logic [9:0]           alienY,
  input  logic                 wave_reset,
  output logic                 has_collided,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic                 kill_valid,
  output logic [5:0]           kill_points,
  output logic                 all_dead
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HIT} state_t;

  logic          r_vs_meta, r_vs_sync, r_vs_prev;
  logic          w_frame_start;
  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [IW-1:0] r_idx;
  logic [9:0]    r_mx, r_my, r_ax, r_ay;
  logic          r_has_collided;
  logic [N-1:0]  r_alive;
  logic          r_kill_valid;
  logic [5:0]    r_kill_points;

  logic [10:0]   w_mx, w_my, w_al, w_at;
  logic          w_hit, w_last;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_frame_start = r_vs_sync & ~r_vs_prev;

  // 11-bit sums so positions near the right/bottom of the screen never wrap
  assign w_mx = {1'b0, r_mx};
  assign w_my = {1'b0, r_my};
  assign w_al = {1'b0, r_ax} + 11'(r_col) * 11'(COL_PITCH);
  assign w_at = {1'b0, r_ay} + 11'(r_row) * 11'(ROW_PITCH);

  assign w_hit = (w_mx < w_al + 11'(ALIEN_W)) && (w_mx + 11'(MISSILE_W) > w_al) &&
                 (w_my < w_at + 11'(ALIEN_H)) && (w_my + 11'(MISSILE_H) > w_at);
  assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);

  function automatic logic [5:0] row_points(input logic [RW-1:0] row);
    if (row == '0)
      return 6'd30;
    else if (row <= RW'(2))
      return 6'd20;
    else
      return 6'd10;
  endfunction

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_col          <= '0;
      r_idx          <= '0;
      r_mx           <= '0;
      r_my           <= '0;
      r_ax           <= '0;
      r_ay           <= '0;
      r_has_collided <= 1'b0;
      r_alive        <= '1;
      r_kill_valid   <= 1'b0;
      r_kill_points  <= '0;
    end else begin
      r_kill_valid <= 1'b0;
      if (wave_reset) begin
        r_alive        <= '1;
        r_has_collided <= 1'b0;
        r_state        <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_frame_start) begin
              r_has_collided <= 1'b0;
              if (missile_exists) begin
                r_mx    <= playerMissileX;
                r_my    <= playerMissileY;
                r_ax    <= alienX;
                r_ay    <= alienY;
                r_row   <= '0;
                r_col   <= '0;
                r_idx   <= '0;
                r_state <= S_SCAN;
              end
            end
          end
          S_SCAN: begin
            // Stop on the first live overlap; row/col/idx stay on the victim
            if (w_hit && r_alive[r_idx]) begin
              r_state <= S_HIT;
            end else if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
              if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
          S_HIT: begin
            r_alive[r_idx] <= 1'b0;
            r_has_collided <= 1'b1;
            r_kill_valid   <= 1'b1;
            r_kill_points  <= row_points(r_row);
            r_state        <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign has_collided = r_has_collided;
  assign alive_mask   = r_alive;
  assign kill_valid   = r_kill_valid;
  assign kill_points  = r_kill_points;
  assign all_dead     = ~|r_alive;

endmodule
